// File: rtl/neuro_pkg.sv
// neuro_pkg: shared state encoding and default constants for the neuro stimulation path
package neuro_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE    = 2'b00;
  localparam state_t S_MONITOR = 2'b01;
  localparam state_t S_STIM    = 2'b10;
  localparam state_t S_REFRACT = 2'b11;
  localparam int DEF_WIN_LEN     = 256;
  localparam int DEF_CONFIRM_N   = 3;
  localparam int DEF_STIM_CYCLES = 1024;
  localparam int DEF_REFRACT_WIN = 8;
  localparam int DEF_CNT_WIDTH   = 16;
  localparam int DATA_WIDTH      = 32;
endpackage

// File: rtl/window_counter.sv
// window_counter: frames accepted samples into WIN_LEN windows, pulsing win_end after the last one
module window_counter
  import neuro_pkg::*;
#(
  parameter int WIN_LEN   = DEF_WIN_LEN,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic win_end
);
  localparam logic [CNT_WIDTH-1:0] W_LAST = CNT_WIDTH'(WIN_LEN - 1);
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_win_end;
  logic                 w_last;
  assign w_last  = r_cnt == W_LAST;
  assign win_end = r_win_end;
  // sample position within the window; clr discards any partial window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_win_end <= 1'b0;
    end else if (clr) begin
      r_cnt     <= '0;
      r_win_end <= 1'b0;
    end else begin
      r_win_end <= inc & w_last;
      if (inc) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/stim_scheduler.sv
// stim_scheduler: debounces per-window seizure flags and drives a timed stimulation pulse plus refractory period
module stim_scheduler
  import neuro_pkg::*;
#(
  parameter int WIN_LEN     = DEF_WIN_LEN,
  parameter int CONFIRM_N   = DEF_CONFIRM_N,
  parameter int STIM_CYCLES = DEF_STIM_CYCLES,
  parameter int REFRACT_WIN = DEF_REFRACT_WIN,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sample_valid,
  input  logic                 seizure,
  output logic                 dp_en,
  output logic                 win_end,
  output logic                 stimulation,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stim_count
);
  localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(CONFIRM_N - 1);
  localparam logic [CNT_WIDTH-1:0] S_LAST = CNT_WIDTH'(STIM_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] R_LAST = CNT_WIDTH'(REFRACT_WIN - 1);
  state_t               r_state, w_state_nx;
  logic [CNT_WIDTH-1:0] r_confirm, w_confirm_nx;
  logic [CNT_WIDTH-1:0] r_stim_cnt, w_stim_cnt_nx;
  logic [CNT_WIDTH-1:0] r_refr, w_refr_nx;
  logic [CNT_WIDTH-1:0] r_stim_count, w_stim_count_nx;
  logic                 w_win_end;
  logic                 w_clr;
  logic                 w_inc;
  assign dp_en       = r_state != S_IDLE;
  assign stimulation = r_state == S_STIM;
  assign state       = r_state;
  assign stim_count  = r_stim_count;
  assign win_end     = w_win_end;
  assign w_inc       = sample_valid & dp_en;
  assign w_clr       = !en | (r_state == S_IDLE);
  window_counter #(
    .WIN_LEN  (WIN_LEN),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_win (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_clr),
    .inc    (w_inc),
    .win_end(w_win_end)
  );
  // next state and counters; dropping en overrides everything and keeps only stim_count
  always_comb begin
    w_state_nx      = r_state;
    w_confirm_nx    = r_confirm;
    w_stim_cnt_nx   = r_stim_cnt;
    w_refr_nx       = r_refr;
    w_stim_count_nx = r_stim_count;
    if (!en) begin
      w_state_nx    = S_IDLE;
      w_confirm_nx  = '0;
      w_stim_cnt_nx = '0;
      w_refr_nx     = '0;
    end else begin
      case (r_state)
        S_IDLE: w_state_nx = S_MONITOR;
        S_MONITOR: begin
          if (w_win_end) begin
            if (!seizure) w_confirm_nx = '0;
            else if (r_confirm == C_LAST) begin
              w_state_nx      = S_STIM;
              w_confirm_nx    = '0;
              w_stim_count_nx = &r_stim_count ? r_stim_count : r_stim_count + 1'b1;
            end else w_confirm_nx = r_confirm + 1'b1;
          end
        end
        S_STIM: begin
          w_state_nx    = r_stim_cnt == S_LAST ? S_REFRACT : S_STIM;
          w_stim_cnt_nx = r_stim_cnt == S_LAST ? '0 : r_stim_cnt + 1'b1;
        end
        default: begin
          if (w_win_end) begin
            w_state_nx   = r_refr == R_LAST ? S_MONITOR : S_REFRACT;
            w_refr_nx    = r_refr == R_LAST ? '0 : r_refr + 1'b1;
            w_confirm_nx = '0;
          end
        end
      endcase
    end
  end
  // state and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_confirm    <= '0;
      r_stim_cnt   <= '0;
      r_refr       <= '0;
      r_stim_count <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_confirm    <= w_confirm_nx;
      r_stim_cnt   <= w_stim_cnt_nx;
      r_refr       <= w_refr_nx;
      r_stim_count <= w_stim_count_nx;
    end
  end
endmodule

// File: tb/tb_stim_scheduler.sv
// tb_stim_scheduler: scoreboard bench for stim_scheduler with a behavioural cycle model
module tb_stim_scheduler;
  localparam int WIN   = 4;
  localparam int CONF  = 3;
  localparam int STIMC = 5;
  localparam int REFR  = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        sample_valid = 1'b1;
  logic        seizure = 1'b0;
  logic        dp_en, win_end, stimulation;
  logic [1:0]  state;
  logic [15:0] stim_count;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] q[$];
  logic [1:0]  m_state;
  logic        m_we;
  int          m_pos, m_conf, m_left, m_rleft, m_sc;
  logic        g_we;
  int          n;
  stim_scheduler #(
    .WIN_LEN    (WIN),
    .CONFIRM_N  (CONF),
    .STIM_CYCLES(STIMC),
    .REFRACT_WIN(REFR),
    .CNT_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sample_valid(sample_valid),
    .seizure     (seizure),
    .dp_en       (dp_en),
    .win_end     (win_end),
    .stimulation (stimulation),
    .state       (state),
    .stim_count  (stim_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  function automatic logic [31:0] dut_out();
    return {11'b0, dp_en, win_end, stimulation, state, stim_count};
  endfunction
  task automatic mclr();
    m_state = 2'b00;
    m_we    = 1'b0;
    m_pos   = 0;
    m_conf  = 0;
    m_left  = 0;
    m_rleft = 0;
  endtask
  task automatic cyc(input logic r, input logic e, input logic s);
    logic [1:0] ns;
    logic       nwe, pre;
    rst = r; en = e; seizure = s;
    g_we = win_end;
    pre = m_we;
    ns = m_state;
    if (!r) m_sc = 0;
    if (!r || !e) mclr();
    else begin
      nwe   = (m_state != 2'b00) && (m_pos == WIN - 1);
      m_pos = (m_state == 2'b00) ? 0 : (m_pos + 1) % WIN;
      case (m_state)
        2'b00: ns = 2'b01;
        2'b01: if (pre) begin
          if (!s) m_conf = 0;
          else if (m_conf + 1 == CONF) begin
            ns = 2'b10; m_conf = 0; m_left = STIMC;
            if (m_sc < 65535) m_sc++;
          end else m_conf++;
        end
        2'b10: begin
          m_left--;
          if (m_left == 0) begin ns = 2'b11; m_rleft = REFR; end
        end
        default: if (pre) begin
          m_rleft--;
          if (m_rleft == 0) begin ns = 2'b01; m_conf = 0; end
        end
      endcase
      m_we = nwe;
      m_state = ns;
    end
    q.push_back({11'b0, m_state != 2'b00, m_we, m_state == 2'b10, m_state, m_sc[15:0]});
    @(posedge clk);
    #1;
    chk("cycle", dut_out(), q.pop_front());
  endtask
  task automatic win(input logic s);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * WIN && !hit; i++) begin
      cyc(1'b1, 1'b1, s);
      hit = g_we;
    end
    chk("win_seen", {31'b0, hit}, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    mclr();
    m_sc = 0;
    #1;
    chk("rst_outputs", dut_out(), 32'h0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("dp_en_rise", {31'b0, dp_en}, 32'd1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      n += int'(win_end);
    end
    chk("win_end_count", n, 32'd3);
    repeat (3) win(1'b1);
    chk("stim_start", {31'b0, stimulation}, 32'd1);
    chk("stim_count1", {16'b0, stim_count}, 32'd1);
    n = int'(stimulation);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      n += int'(stimulation);
    end
    chk("stim_len", n, 32'd5);
    repeat (4) win(1'b0);
    chk("back_monitor", {30'b0, state}, 32'd1);
    win(1'b1); win(1'b1); win(1'b0); win(1'b1); win(1'b1);
    chk("pattern_no_stim", {15'b0, stimulation, stim_count}, 32'd1);
    win(1'b1);
    chk("pattern_fire", {15'b0, stimulation, stim_count}, {15'b0, 1'b1, 16'd2});
    repeat (5) win(1'b1);
    chk("refract_hold", {13'b0, stimulation, state, stim_count}, {13'b0, 1'b0, 2'b01, 16'd2});
    win(1'b1);
    chk("refire", {15'b0, stimulation, stim_count}, {15'b0, 1'b1, 16'd3});
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("en_drop", {12'b0, dp_en, stimulation, state, stim_count}, {12'b0, 1'b0, 1'b0, 2'b00, 16'd3});
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    win(1'b1); win(1'b1);
    chk("reen_wait", {15'b0, stimulation, stim_count}, 32'd3);
    win(1'b1);
    chk("reen_fire", {15'b0, stimulation, stim_count}, {15'b0, 1'b1, 16'd4});
    repeat (5) cyc(1'b1, 1'b1, 1'b0);
    chk("in_refract", {30'b0, state}, 32'd3);
    #2 rst = 1'b0;
    #1;
    mclr();
    m_sc = 0;
    q.push_back(32'h0);
    chk("async_rst", dut_out(), q.pop_front());
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    repeat (3) win(1'b1);
    chk("resume", {15'b0, stimulation, stim_count}, {15'b0, 1'b1, 16'd1});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
